dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: word-addressed RAM depth; power of two.
REQ-002 Parameter WAIT_CYCLES, default 2: extra wait states per access, 0..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  MEM stage has a load/store request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address (ALU result of the MEM stage).
REQ-008 req_wdata  input  32  store data; the forwarded rs2 value.
REQ-009 req_dmtype  input  3  access type: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned.
REQ-010 req_ready  output  1  controller can accept a request this cycle.
REQ-011 rsp_valid  output  1  one-cycle pulse: access complete.
REQ-012 rsp_rdata  output  32  extended load data; valid while rsp_valid.
REQ-013 misalign  output  1  current response is for a misaligned access; valid while rsp_valid.
REQ-014 stall  output  1  pipeline hold request to the upstream stages.

Function
REQ-015 FSM states are IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Acceptance at a rising edge where req_valid=1 and the state is IDLE; acceptance latches we, addr, wdata and dmtype; later input changes are ignored until the next acceptance.
REQ-017 On acceptance the wait counter loads WAIT_CYCLES and the FSM enters WAIT; with WAIT_CYCLES=0 the FSM goes directly to RESP.
REQ-018 In WAIT the counter decrements each edge; the edge at which the counter reaches 0 performs the access and enters RESP.
REQ-019 rsp_valid SHALL be 1 for exactly the one cycle spent in RESP; RESP always returns to IDLE on the next edge.
REQ-020 If the accepting edge is edge k, rsp_valid is high in the cycle after edge k+WAIT_CYCLES.
REQ-021 req_valid sampled in RESP is not accepted; a held request is re-accepted in IDLE only if still asserted.
REQ-022 stall = req_valid AND NOT rsp_valid (combinational).
REQ-023 Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-024 Stores update byte lanes only:
  - word: all 4 lanes.
  - half: lanes addr[1]*2 and addr[1]*2+1, written from wdata[15:0].
  - byte: lane addr[1:0], written from wdata[7:0].
REQ-025 Loads select the lane(s) by addr[1:0]:
  - 001/011: sign-extend to 32 bits.
  - 010/100: zero-extend to 32 bits.
  - 000: whole word.
REQ-026 rsp_rdata is registered at the access edge; for a store it is 0.
REQ-027 An unknown dmtype (101..111) is treated as word.

Reset
REQ-028 rst=0 at an edge: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, misalign 0.
REQ-029 Reset mid-operation (WAIT) abandons the pending store; no RAM lane changes.
REQ-030 RAM contents are not cleared by reset.

Configuration
REQ-031 Macro DMEM_CTRL_MISALIGN_TRAP_EN defined: an access is misaligned if it is a half with addr[0]=1 or a word with addr[1:0]!=0. Such an access SHALL skip WAIT, enter RESP on the accepting edge with misalign=1 and rsp_rdata=0, and SHALL NOT write RAM.
REQ-032 Macro undefined: the low address bits are masked to natural alignment (half: addr[0]=0; word: addr[1:0]=0); misalign is tied to 0.

Verification
REQ-033 Word store 0xDEADBEEF to 0x10, then word load 0x10 with WAIT_CYCLES=2 -> rsp_valid in the 3rd cycle after acceptance, rdata=0xDEADBEEF, stall high for 3 cycles.
REQ-034 After the word store above, byte store 0x5A to 0x11; byte load 0x11 -> 0x0000005A; half load 0x12 -> 0xFFFFDEAD; half-unsigned load 0x12 -> 0x0000DEAD; word load 0x10 -> 0xDEAD5AEF.
REQ-035 rst=0 while in WAIT of a word store of 0x12345678 to 0x20 -> next cycle IDLE, no rsp_valid; word load 0x20 returns the prior value.
REQ-036 Store 0x11111111 to address 0x1000 with DEPTH_WORDS=1024 -> word load 0x0 returns 0x11111111 (wrap).
REQ-037 With the macro defined, word store to 0x13 -> rsp_valid on the cycle after acceptance with misalign=1, and RAM is unchanged. With the macro undefined, the same store writes word index 4 and misalign=0.
REQ-038 WAIT_CYCLES=0 and back-to-back req_valid held high -> accept and RESP alternate, one response every 2 cycles, req_ready=0 in RESP.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// MEM-stage request/response bus between the pipeline and the data-memory controller.
interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_dmtype;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign;
  logic        stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_dmtype,
    input  req_ready, rsp_valid, rsp_rdata, misalign, stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_dmtype,
    output req_ready, rsp_valid, rsp_rdata, misalign, stall
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-lane word RAM behind an IDLE/WAIT/RESP handshake with WAIT_CYCLES wait states.
// Optional feature macro DMEM_CTRL_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of masking them.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = AW + 2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic is_half(input logic [2:0] dm);
    return (dm == DM_HALF) || (dm == DM_HALFU);
  endfunction

  function automatic logic is_byte(input logic [2:0] dm);
    return (dm == DM_BYTE) || (dm == DM_BYTEU);
  endfunction

  function automatic logic is_signed(input logic [2:0] dm);
    return (dm == DM_HALF) || (dm == DM_BYTE);
  endfunction

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic [3:0]      cnt_nxt;
  logic            lat_we;
  logic [BW-1:0]   lat_addr;
  logic [31:0]     lat_wdata;
  logic [2:0]      lat_dmtype;
  logic            op_we;
  logic [BW-1:0]   op_addr;
  logic [BW-1:0]   eff_addr;
  logic [31:0]     op_wdata;
  logic [2:0]      op_dmtype;
  logic            accept;
  logic            trap;
  logic            do_access;
  logic [31:0]     rd_word;
  logic [15:0]     rd_half;
  logic [7:0]      rd_byte;
  logic [31:0]     load_val;
  logic [31:0]     wr_data;
  logic [3:0]      wr_be;
  logic            rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            misalign;
  logic [31:0]     mem [DEPTH_WORDS];

  assign accept = (state == S_IDLE) && bus.req_valid;

  // In IDLE the access (if any) uses the live bus; afterwards only the latched copy counts.
  always_comb begin
    if (state == S_IDLE) begin
      op_we     = bus.req_we;
      op_addr   = bus.req_addr[BW-1:0];
      op_wdata  = bus.req_wdata;
      op_dmtype = bus.req_dmtype;
    end else begin
      op_we     = lat_we;
      op_addr   = lat_addr;
      op_wdata  = lat_wdata;
      op_dmtype = lat_dmtype;
    end
  end

`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
  // Misaligned half/word requests are flagged at acceptance and never touch the RAM.
  always_comb begin
    eff_addr = op_addr;
    if (is_half(op_dmtype)) begin
      trap = accept && op_addr[0];
    end else if (is_byte(op_dmtype)) begin
      trap = 1'b0;
    end else begin
      trap = accept && (op_addr[1:0] != 2'b00);
    end
  end
`else
  // Without trapping, low address bits are forced to the access size's natural alignment.
  always_comb begin
    trap     = 1'b0;
    eff_addr = op_addr;
    if (is_half(op_dmtype)) begin
      eff_addr[0] = 1'b0;
    end else if (is_byte(op_dmtype)) begin
      eff_addr = op_addr;
    end else begin
      eff_addr[1:0] = 2'b00;
    end
  end
`endif

  // Next-state logic; do_access marks the edge that reads or writes the RAM.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_access = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (trap) begin
            state_nxt = S_RESP;
            cnt_nxt   = 4'd0;
          end else if (WAIT_LOAD == 4'd0) begin
            state_nxt = S_RESP;
            do_access = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = S_RESP;
          cnt_nxt   = 4'd0;
          do_access = 1'b1;
        end else begin
          state_nxt = S_WAIT;
          cnt_nxt   = cnt - 4'd1;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Lane selection for loads and lane enables for stores.
  always_comb begin
    rd_word = mem[eff_addr[BW-1:2]];
    rd_half = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (eff_addr[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      2'b11:   rd_byte = rd_word[31:24];
      default: rd_byte = 8'd0;
    endcase
    if (is_half(op_dmtype)) begin
      load_val = is_signed(op_dmtype) ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
      wr_data  = {op_wdata[15:0], op_wdata[15:0]};
      wr_be    = eff_addr[1] ? 4'b1100 : 4'b0011;
    end else if (is_byte(op_dmtype)) begin
      load_val = is_signed(op_dmtype) ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
      wr_data  = {4{op_wdata[7:0]}};
      wr_be    = 4'b0001 << eff_addr[1:0];
    end else begin
      load_val = rd_word;
      wr_data  = op_wdata;
      wr_be    = 4'b1111;
    end
  end

  // RAM write port; gated by reset so a store abandoned in WAIT leaves every lane untouched.
  always_ff @(posedge clk) begin
    if (rst && do_access && op_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[eff_addr[BW-1:2]][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  // Control state, request latch and registered response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'd0;
      misalign   <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= 32'd0;
      lat_dmtype <= 3'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rsp_valid <= (state_nxt == S_RESP);
      misalign  <= trap;
      if (accept) begin
        lat_we     <= bus.req_we;
        lat_addr   <= bus.req_addr[BW-1:0];
        lat_wdata  <= bus.req_wdata;
        lat_dmtype <= bus.req_dmtype;
      end
      if (trap) begin
        rsp_rdata <= 32'd0;
      end else if (do_access) begin
        rsp_rdata <= op_we ? 32'd0 : load_val;
      end
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.misalign  = misalign;
  assign bus.stall     = bus.req_valid & ~rsp_valid;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: timestamp/byte-array reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_dmem_ctrl;
  localparam int WM    = 2;
  localparam int DEPTH = 1024;
  localparam int NB    = 4 * DEPTH;
`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_ctrl_if bus ();
  dmem_ctrl_if bus0 ();

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WM)) dut  (.clk(clk), .rst(rst), .bus(bus));
  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0))  dut0 (.clk(clk), .rst(rst), .bus(bus0));

  int total = 0;
  int bad = 0;
  int last_stalls = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mm [NB];
  int          edge_n    = 0;
  int          free_edge = 0;
  int          resp_edge = -1;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_mis   = 1'b0;
  logic        pend      = 1'b0;
  logic [31:0] p_addr    = 32'd0;
  logic [31:0] p_wdata   = 32'd0;
  logic [2:0]  p_ty      = 3'd0;
  logic        exp_v;

  function automatic int msize(input logic [2:0] ty);
    if (ty == 3'd1 || ty == 3'd2) return 2;
    if (ty == 3'd3 || ty == 3'd4) return 1;
    return 4;
  endfunction

  function automatic int m_idx(input logic [31:0] a, input int n, input int i);
    logic [31:0] b;
    b = (a & ~32'(n - 1)) + 32'(i);
    return int'(b % 32'(NB));
  endfunction

  function automatic logic m_mis(input logic [31:0] a, input logic [2:0] ty);
    return TRAP_ON && ((a % 32'(msize(ty))) != 32'd0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] ty);
    int n;
    logic [31:0] v;
    n = msize(ty);
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mm[m_idx(a, n, i)];
    if ((ty == 3'd1 || ty == 3'd3) && v[8*n-1]) begin
      for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  // A request accepted at edge k answers after edge k+W (k for a trap); the next acceptance is two edges later.
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!rst) begin
      free_edge <= edge_n + 1;
      resp_edge <= -1;
      pend      <= 1'b0;
    end else begin
      if (pend && edge_n == resp_edge) begin
        for (int i = 0; i < msize(p_ty); i++) mm[m_idx(p_addr, msize(p_ty), i)] <= p_wdata[8*i +: 8];
        pend <= 1'b0;
      end
      if (edge_n >= free_edge && bus.req_valid) begin
        if (m_mis(bus.req_addr, bus.req_dmtype)) begin
          resp_edge <= edge_n;
          free_edge <= edge_n + 2;
          exp_rdata <= 32'd0;
          exp_mis   <= 1'b1;
        end else begin
          resp_edge <= edge_n + WM;
          free_edge <= edge_n + WM + 2;
          exp_mis   <= 1'b0;
          exp_rdata <= bus.req_we ? 32'd0 : m_load(bus.req_addr, bus.req_dmtype);
          if (bus.req_we) begin
            pend    <= 1'b1;
            p_addr  <= bus.req_addr;
            p_wdata <= bus.req_wdata;
            p_ty    <= bus.req_dmtype;
          end
        end
      end
    end
  end

  assign exp_v = (resp_edge == edge_n - 1);

  // Every-cycle comparison of the main controller against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", bus.req_ready, edge_n >= free_edge);
      check("rsp_valid", bus.rsp_valid, exp_v);
      check("stall", bus.stall, bus.req_valid & ~exp_v);
      if (exp_v) begin
        check("rdata", bus.rsp_rdata, exp_rdata);
        check("misalign", bus.misalign, exp_mis);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run(input string nm, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] ty, input logic [31:0] exp_rd, input int exp_lat, input logic exp_mis);
    int n;
    bit got;
    logic [31:0] rd;
    logic mis;
    n = 0; got = 1'b0; rd = 32'd0; mis = 1'b0; last_stalls = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd; bus.req_dmtype = ty;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.stall) last_stalls++;
      if (bus.rsp_valid) begin
        got = 1'b1; rd = bus.rsp_rdata; mis = bus.misalign;
      end else if (n == 2) begin
        bus.req_we = ~we; bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_dmtype = 3'd4;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check({nm, "_seen"}, 32'(got), 32'd1);
    check({nm, "_rdata"}, rd, exp_rd);
    check({nm, "_lat"}, 32'(n - 1), 32'(exp_lat));
    check({nm, "_mis"}, 32'(mis), 32'(exp_mis));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int nrsp;
    bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_addr = 32'd0;  bus.req_wdata = 32'd0;  bus.req_dmtype = 3'd0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 32'd0; bus0.req_wdata = 32'd0; bus0.req_dmtype = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.req_ready, 32'd1);
    check("rst_rsp", bus.rsp_valid, 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_mis", bus.misalign, 32'd0);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // word store / load with two wait states
    run("st_word", 1'b1, 32'h10, 32'hDEADBEEF, 3'd0, 32'd0, 3, 1'b0);
    check("st_stall_cycles", 32'(last_stalls), 32'd3);
    run("ld_word", 1'b0, 32'h10, 32'd0, 3'd0, 32'hDEADBEEF, 3, 1'b0);
    check("ld_stall_cycles", 32'(last_stalls), 32'd3);

    // byte lane update and extension rules
    run("st_byte", 1'b1, 32'h11, 32'h0000005A, 3'd3, 32'd0, 3, 1'b0);
    run("ld_byte", 1'b0, 32'h11, 32'd0, 3'd3, 32'h0000005A, 3, 1'b0);
    run("ld_half", 1'b0, 32'h12, 32'd0, 3'd1, 32'hFFFFDEAD, 3, 1'b0);
    run("ld_halfu", 1'b0, 32'h12, 32'd0, 3'd2, 32'h0000DEAD, 3, 1'b0);
    run("ld_merged", 1'b0, 32'h10, 32'd0, 3'd0, 32'hDEAD5AEF, 3, 1'b0);
    run("ld_sbyte", 1'b0, 32'h13, 32'd0, 3'd3, 32'hFFFFFFDE, 3, 1'b0);
    run("ld_ubyte", 1'b0, 32'h10, 32'd0, 3'd4, 32'h000000EF, 3, 1'b0);
    run("ld_dm_unk", 1'b0, 32'h10, 32'd0, 3'd7, 32'hDEAD5AEF, 3, 1'b0);

    // half/byte stores into a cleared word
    run("st_zero", 1'b1, 32'h14, 32'd0, 3'd0, 32'd0, 3, 1'b0);
    run("st_half", 1'b1, 32'h16, 32'hBEEF1234, 3'd1, 32'd0, 3, 1'b0);
    run("st_ubyte", 1'b1, 32'h15, 32'h000000FF, 3'd4, 32'd0, 3, 1'b0);
    run("ld_hb", 1'b0, 32'h14, 32'd0, 3'd0, 32'h1234FF00, 3, 1'b0);
    run("ld_sb_ff", 1'b0, 32'h15, 32'd0, 3'd3, 32'hFFFFFFFF, 3, 1'b0);
    run("ld_h_pos", 1'b0, 32'h16, 32'd0, 3'd1, 32'h00001234, 3, 1'b0);

    // misaligned word store
`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
    run("mis_st", 1'b1, 32'h13, 32'hA5A5A5A5, 3'd0, 32'd0, 1, 1'b1);
    run("mis_chk", 1'b0, 32'h10, 32'd0, 3'd0, 32'hDEAD5AEF, 3, 1'b0);
    run("mis_half", 1'b0, 32'h11, 32'd0, 3'd1, 32'd0, 1, 1'b1);
`else
    run("mis_st", 1'b1, 32'h13, 32'hA5A5A5A5, 3'd0, 32'd0, 3, 1'b0);
    run("mis_chk", 1'b0, 32'h10, 32'd0, 3'd0, 32'hA5A5A5A5, 3, 1'b0);
    run("mis_half", 1'b0, 32'h11, 32'd0, 3'd1, 32'hFFFFA5A5, 3, 1'b0);
`endif

    // reset in WAIT abandons the store
    run("st_prior", 1'b1, 32'h20, 32'hCAFEF00D, 3'd0, 32'd0, 3, 1'b0);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h12345678; bus.req_dmtype = 3'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("wait_busy", bus.req_ready, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_wait_ready", bus.req_ready, 32'd1);
    check("rst_wait_rsp", bus.rsp_valid, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_wait_quiet", bus.rsp_valid, 32'd0);
    @(posedge clk);
    #1;
    run("ld_prior", 1'b0, 32'h20, 32'd0, 3'd0, 32'hCAFEF00D, 3, 1'b0);

    // address wrap modulo DEPTH_WORDS*4
    run("st_wrap", 1'b1, 32'h1000, 32'h11111111, 3'd0, 32'd0, 3, 1'b0);
    run("ld_wrap", 1'b0, 32'h0, 32'd0, 3'd0, 32'h11111111, 3, 1'b0);

    // zero wait states, request held high
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 32'h40; bus0.req_wdata = 32'h77; bus0.req_dmtype = 3'd0;
    nrsp = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("b2b_rsp", bus0.rsp_valid, 32'((i % 2) == 0));
      check("b2b_ready", bus0.req_ready, 32'((i % 2) != 0));
      if (bus0.rsp_valid) nrsp++;
    end
    check("b2b_count", 32'(nrsp), 32'd3);
    @(posedge clk);
    #1;
    bus0.req_we = 1'b0;
    @(negedge clk);
    check("w0_pre", bus0.rsp_valid, 32'd0);
    @(negedge clk);
    check("w0_rsp", bus0.rsp_valid, 32'd1);
    check("w0_rdata", bus0.rsp_rdata, 32'h77);
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
